// File: rtl/if_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response
// channel and the instruction hand-off towards decode.
interface if_fetch_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;

   modport master (
      output imem_req_valid,
      input  imem_req_ready,
      output imem_req_addr,
      input  imem_rsp_valid,
      input  imem_rsp_data,
      output inst_valid,
      input  inst_ready,
      output inst_data,
      output inst_pc
   );

   modport slave (
      input  imem_req_valid,
      output imem_req_ready,
      input  imem_req_addr,
      output imem_rsp_valid,
      output imem_rsp_data,
      input  inst_valid,
      output inst_ready,
      input  inst_data,
      input  inst_pc
   );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: one outstanding imem request, kill-on-redirect,
// and a two-entry instruction buffer feeding decode.
module if_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   if_fetch_if.master  bus
);

   localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t      state;
   state_t      state_nx;
   logic [31:0] fetch_pc;
   logic [31:0] req_addr;
   logic [31:0] tgt;
   logic        kill;
   logic        xfer;
   logic        rsp;
   logic        push;
   logic        pop;
   logic        issue;
   logic        have_inst;
   logic [1:0]  cnt;
   logic [2:0]  occ;
   logic        wp;
   logic        rp;
   logic [31:0] fifo_data [2];
   logic [31:0] fifo_pc   [2];

   assign tgt       = redirect_pc & 32'hFFFF_FFFC;
   assign xfer      = (state == REQ) && bus.imem_req_ready;
   assign rsp       = (state == WAIT) && bus.imem_rsp_valid;
   assign push      = rsp && !kill && !redirect_valid;
   assign have_inst = (cnt != 2'd0);
   assign pop       = have_inst && bus.inst_ready && !redirect_valid;

   // Occupancy after this cycle, counting the response being written;
   // a redirect empties the buffer so it never blocks the refetch.
   assign occ   = redirect_valid ? 3'd0
                                 : {1'b0, cnt} + {2'b0, push};
   assign issue = ena && (occ < DEPTH) && ((state == IDLE) || rsp);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (issue) state_nx = REQ;
         REQ:     if (bus.imem_req_ready) state_nx = WAIT;
         WAIT:    if (bus.imem_rsp_valid) state_nx = issue ? REQ : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
         req_addr <= RESET_PC;
         kill     <= 1'b0;
         cnt      <= 2'd0;
         wp       <= 1'b0;
         rp       <= 1'b0;
      end else begin
         if (issue) req_addr <= redirect_valid ? tgt : fetch_pc;
         // A killed transfer is stale: fetch_pc already holds the target.
         if (redirect_valid)     fetch_pc <= tgt;
         else if (xfer && !kill) fetch_pc <= fetch_pc + 32'd4;
         if (redirect_valid)
            kill <= (state == REQ) ||
                    ((state == WAIT) && !bus.imem_rsp_valid);
         else if (rsp)
            kill <= 1'b0;
         if (redirect_valid) begin
            cnt <= 2'd0;
            wp  <= 1'b0;
            rp  <= 1'b0;
         end else begin
            if (push) wp <= ~wp;
            if (pop)  rp <= ~rp;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wp] <= bus.imem_rsp_data;
         fifo_pc[wp]   <= req_addr;
      end
   end

   assign bus.imem_req_valid = (state == REQ);
   assign bus.imem_req_addr  = req_addr;
   assign bus.inst_valid     = have_inst;
   assign bus.inst_data      = have_inst ? fifo_data[rp] : 32'd0;
   assign bus.inst_pc        = have_inst ? fifo_pc[rp]   : 32'd0;

endmodule
